// File: rtl/sbus_encoder_tx.sv
// rtl/sbus_encoder_tx.sv - S.BUS 25-byte frame transmitter (100 kbaud 8E2) with fixed frame period
// SBUS_TX_INVERT_EN: when defined, txd uses native inverted S.BUS polarity (idle low).
module sbus_encoder_tx #(
  parameter int CLK_FREQ_HZ     = 50000000,
  parameter int BAUD            = 100000,
  parameter int FRAME_PERIOD_US = 14000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [175:0] ch_data,
  input  logic [3:0]   flags,
  output logic         txd,
  output logic         busy,
  output logic         frame_done
);
  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int FC  = (CLK_FREQ_HZ / 1000000) * FRAME_PERIOD_US;
  localparam int PW  = $clog2(FC);
  localparam int DW  = $clog2(DIV);
`ifdef SBUS_TX_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif
  localparam logic IDLE_LVL = ~INV;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t         r_state;
  logic [PW-1:0]  r_period;
  logic [DW-1:0]  r_div;
  logic [3:0]     r_bitcnt;
  logic [4:0]     r_idx;
  logic [175:0]   r_shadow;
  logic [3:0]     r_flags;
  logic [11:0]    r_word;
  logic           r_txd;
  logic           r_busy;
  logic           r_done;

  logic [207:0]   w_frame;
  logic [5:0]     w_idx_nxt;
  logic [7:0]     w_next_byte;
  logic [11:0]    w_next_word;
  logic           w_tick;

  // UART character, bit 0 transmitted first: start, d0..d7, even parity, two stops
  function automatic logic [11:0] frame_word(input logic [7:0] b);
    return {2'b11, ^b, b, 1'b0};
  endfunction

  // Byte k of the frame is w_frame[8k +: 8]; one spare pad byte keeps idx+1 in range
  assign w_frame     = {16'h0000, 4'h0, r_flags, r_shadow, 8'h0F};
  assign w_idx_nxt   = {1'b0, r_idx} + 6'd1;
  assign w_next_byte = w_frame[{w_idx_nxt, 3'b000} +: 8];
  assign w_next_word = frame_word(w_next_byte);
  assign w_tick      = enable && (r_period == PW'(FC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_period <= '0;
      r_div    <= '0;
      r_bitcnt <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_flags  <= '0;
      r_word   <= '0;
      r_txd    <= IDLE_LVL;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (!enable || w_tick) r_period <= '0;
      else                   r_period <= r_period + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_tick) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shadow <= ch_data;
          r_flags  <= flags;
          r_idx    <= '0;
          r_div    <= '0;
          r_bitcnt <= '0;
          r_word   <= frame_word(8'h0F) >> 1;
          r_txd    <= frame_word(8'h0F) ^ {11'b0, INV} ? ((frame_word(8'h0F) & 12'h001) != 0) ^ INV : INV;
          r_busy   <= 1'b1;
          r_state  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_div == DW'(DIV - 1)) begin
            r_div <= '0;
            if (r_bitcnt == 4'd11) begin
              if (r_idx == 5'd24) begin
                r_txd   <= IDLE_LVL;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_idx    <= w_idx_nxt[4:0];
                r_bitcnt <= '0;
                r_txd    <= w_next_word[0] ^ INV;
                r_word   <= w_next_word >> 1;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 4'd1;
              r_txd    <= r_word[0] ^ INV;
              r_word   <= r_word >> 1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign txd        = r_txd;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_sbus_encoder_tx.sv
// tb/tb_sbus_encoder_tx.sv - randomized self-checking bench for sbus_encoder_tx
`timescale 1ns/1ps
module tb_sbus_encoder_tx;
  localparam int CLK_HZ = 2000000;
  localparam int BAUD   = 125000;
  localparam int PER_US = 2500;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int FC     = (CLK_HZ / 1000000) * PER_US;
`ifdef SBUS_TX_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif
  localparam logic IDLE_LVL = ~INV;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic [175:0] ch_data;
  logic [3:0]   flags;
  logic         txd;
  logic         busy;
  logic         frame_done;

  int unsigned  cyc = 0;
  int           checks = 0;
  int           failures = 0;
  int           chv[16];
  int           flv;
  logic [11:0]  obs_w[25];

  sbus_encoder_tx #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .FRAME_PERIOD_US(PER_US)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ch_data(ch_data),
    .flags(flags), .txd(txd), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [175:0] pack_ch(input int v);
    logic [175:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[11*i +: 11] = 11'(v);
    return r;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < 16; i++) ch_data[11*i +: 11] = 11'(chv[i]);
    flags = 4'(flv);
  endtask

  // Reference: payload is a little-endian bitstream of 16 x 11-bit channels
  function automatic logic [7:0] exp_byte(input int k);
    int b, p;
    if (k == 0)  return 8'h0F;
    if (k == 23) return 8'(flv & 15);
    if (k == 24) return 8'h00;
    b = 0;
    for (int j = 0; j < 8; j++) begin
      p = 8 * (k - 1) + j;
      b = b + (((chv[p / 11] >> (p % 11)) & 1) << j);
    end
    return 8'(b);
  endfunction

  function automatic logic [11:0] exp_word(input int k);
    int b;
    b = int'(exp_byte(k));
    return 12'((b << 1) | (($countones(b) % 2) << 9) | (3 << 10));
  endfunction

  task automatic rx_frame(input int chg_bit, input logic [175:0] chg_ch, input logic chg_en,
                          output int unsigned t_start);
    int n, v, p;
    logic [11:0] w0, w1;
    n = 0;
    t_start = 0;
    while (txd === IDLE_LVL && n < 3 * FC) begin
      @(negedge clk);
      n++;
    end
    if (txd === IDLE_LVL) begin
      check("start_timeout", 1, 0);
      return;
    end
    t_start = cyc;
    check("busy_at_start", busy, 1);
    for (int bt = 0; bt < 25; bt++) begin
      w0 = '0;
      w1 = '0;
      for (int j = 0; j < 12; j++) begin
        if (bt * 12 + j == chg_bit) begin
          ch_data = chg_ch;
          enable  = chg_en;
        end
        w0[j] = txd ^ INV;
        repeat (DIV - 1) @(negedge clk);
        w1[j] = txd ^ INV;
        @(negedge clk);
      end
      obs_w[bt] = w0;
      check($sformatf("byte%0d_first", bt), w0, exp_word(bt));
      check($sformatf("byte%0d_last", bt), w1, exp_word(bt));
    end
    check("done_pulse", frame_done, 1);
    check("busy_fall", busy, 0);
    @(negedge clk);
    check("done_one_cycle", frame_done, 0);
    // Decoder view: rebuild channels from the received bytes
    for (int i = 0; i < 16; i++) begin
      v = 0;
      for (int b = 0; b < 11; b++) begin
        p = 11 * i + b;
        v = v | (int'(obs_w[1 + p / 8][1 + p % 8]) << b);
      end
      check($sformatf("loop_ch%0d", i), v, chv[i] & 2047);
    end
    check("loop_flags", obs_w[23][4:1], flv & 15);
  endtask

  initial begin
    int unsigned t_rel, t0, t1;
    int act;
    logic [175:0] keep;
    reset_n = 1'b0;
    enable  = 1'b1;
    for (int i = 0; i < 16; i++) chv[i] = 'h400;
    flv = 0;
    apply_inputs();

    repeat (2) @(negedge clk);
    check("rst_txd", txd, IDLE_LVL);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    act = 0;
    for (int i = 0; i < 2 * FC; i++) begin
      @(negedge clk);
      if (txd !== IDLE_LVL || busy !== 1'b0 || frame_done !== 1'b0) act++;
    end
    check("rst_quiet", act, 0);

    reset_n = 1'b1;
    t_rel = cyc;
    rx_frame(-1, '0, 1'b1, t0);
    check("first_start_window", ((t0 - t_rel) == FC + 1) || ((t0 - t_rel) == FC + 2), 1);
    check("hdr_word", obs_w[0], 12'hC1E);
    check("hdr_b2", obs_w[2][8:1], 8'h04);
    check("hdr_b3", obs_w[3][8:1], 8'h20);
    check("hdr_b5", obs_w[5][8:1], 8'h01);
    check("hdr_b6", obs_w[6][8:1], 8'h08);

    for (int i = 0; i < 16; i++) chv[i] = 0;
    chv[0] = 'h7FF;
    flv = 9;
    apply_inputs();
    rx_frame(-1, '0, 1'b1, t1);
    check("period", t1 - t0, FC);
    check("pack_b1", obs_w[1], 12'hDFE);
    check("pack_b2", obs_w[2], 12'hE0E);
    check("pack_b23", obs_w[23], 12'hC12);

    for (int i = 0; i < 16; i++) chv[i] = 0;
    flv = 0;
    apply_inputs();
    t0 = t1;
    rx_frame(5 * 12 + 6, pack_ch('h7FF), 1'b1, t1);
    check("period_tear", t1 - t0, FC);
    for (int i = 0; i < 16; i++) chv[i] = 'h7FF;
    t0 = t1;
    rx_frame(-1, '0, 1'b1, t1);
    check("tear_next_b10", obs_w[10][8:1], 8'hFF);

    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) chv[i] = int'($urandom_range(0, 2047));
      flv = int'($urandom_range(0, 15));
      apply_inputs();
      t0 = t1;
      rx_frame(-1, '0, 1'b1, t1);
      check("period_rand", t1 - t0, FC);
    end

    keep = ch_data;
    rx_frame(10 * 12 + 3, keep, 1'b0, t1);
    act = 0;
    for (int i = 0; i < 3 * FC; i++) begin
      @(negedge clk);
      if (txd !== IDLE_LVL || busy !== 1'b0 || frame_done !== 1'b0) act++;
    end
    check("drop_quiet", act, 0);

    for (int i = 0; i < 16; i++) chv[i] = 100 * i + 3;
    flv = 6;
    apply_inputs();
    enable = 1'b1;
    t_rel = cyc;
    rx_frame(-1, '0, 1'b1, t0);
    check("reenable_window", ((t0 - t_rel) == FC + 1) || ((t0 - t_rel) == FC + 2), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
